// File: rtl/core_mem_bridge.sv
// Merges icache fill and data-side requests onto one tagged memory channel and
// routes out-of-order memory responses back to their owner; ic_flush drops in-flight fills.
module core_mem_bridge #(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int MAX_OUT = 4,
    localparam int TAG_W   = $clog2(MAX_OUT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_wr,
    input  logic [DATA_W-1:0] dc_req_wdata,
    input  logic              ic_flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [TAG_W-1:0]  mem_req_tag,
    input  logic              mem_rsp_valid,
    input  logic [TAG_W-1:0]  mem_rsp_tag,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              ic_rsp_valid,
    output logic [DATA_W-1:0] ic_rsp_data,
    output logic              dc_rsp_valid,
    output logic [DATA_W-1:0] dc_rsp_data,
    output logic              busy,
    output logic              protocol_err
);

    typedef enum logic {
        SIDE_IC = 1'b0,
        SIDE_DC = 1'b1
    } side_t;

    side_t rr_ptr;

    // Tag table; owner bit uses the side_t encoding (0=ic, 1=dc)
    logic [MAX_OUT-1:0] tag_valid;
    logic [MAX_OUT-1:0] tag_owner;
    logic [MAX_OUT-1:0] tag_drop;
    logic [MAX_OUT-1:0] tag_wr;

    logic [TAG_W-1:0] free_idx;
    logic             free_found;
    logic             stage_free;
    logic             ic_can;
    logic             dc_can;
    logic             grant_ic;
    logic             grant_dc;
    logic             grant;
    logic             rsp_hit;
    logic             rsp_owner;
    logic             rsp_drop;
    logic             rsp_wr;

    // Lowest free index wins; only current valid bits count, so a tag freed
    // by this cycle's response is not reusable until the next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!tag_valid[i]) begin
                free_found = 1'b1;
                free_idx   = TAG_W'(i);
            end
        end
    end

    assign stage_free = !mem_req_valid || mem_req_ready;
    assign ic_can     = ic_req_valid && !ic_flush;
    assign dc_can     = dc_req_valid;

    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (stage_free && free_found) begin
            if (ic_can && dc_can) begin
                if (rr_ptr == SIDE_IC) grant_ic = 1'b1;
                else                   grant_dc = 1'b1;
            end else if (ic_can) begin
                grant_ic = 1'b1;
            end else if (dc_can) begin
                grant_dc = 1'b1;
            end
        end
    end

    assign grant        = grant_ic || grant_dc;
    assign ic_req_ready = grant_ic;
    assign dc_req_ready = grant_dc;

    assign rsp_hit   = mem_rsp_valid && tag_valid[mem_rsp_tag];
    assign rsp_owner = tag_owner[mem_rsp_tag];
    assign rsp_drop  = tag_drop[mem_rsp_tag];
    assign rsp_wr    = tag_wr[mem_rsp_tag];

    assign busy = (|tag_valid) || mem_req_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wr    <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_tag   <= '0;
            rr_ptr        <= SIDE_IC;
        end else if (grant) begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= grant_ic ? ic_req_addr : dc_req_addr;
            mem_req_wr    <= grant_dc && dc_req_wr;
            mem_req_wdata <= grant_dc ? dc_req_wdata : '0;
            mem_req_tag   <= free_idx;
            rr_ptr        <= grant_ic ? SIDE_DC : SIDE_IC;
        end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
        end
    end

    // Grant and response always touch different entries, so both updates apply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
            tag_drop  <= '0;
            tag_wr    <= '0;
        end else begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (ic_flush && tag_valid[i] && !tag_owner[i]) tag_drop[i] <= 1'b1;
            end
            if (rsp_hit) tag_valid[mem_rsp_tag] <= 1'b0;
            if (grant) begin
                tag_valid[free_idx] <= 1'b1;
                tag_owner[free_idx] <= grant_dc;
                tag_drop[free_idx]  <= 1'b0;
                tag_wr[free_idx]    <= grant_dc && dc_req_wr;
            end
        end
    end

    // A flush in the response cycle suppresses the fill even if drop is not yet set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ic_rsp_valid <= 1'b0;
            ic_rsp_data  <= '0;
            dc_rsp_valid <= 1'b0;
            dc_rsp_data  <= '0;
            protocol_err <= 1'b0;
        end else begin
            ic_rsp_valid <= 1'b0;
            ic_rsp_data  <= '0;
            dc_rsp_valid <= 1'b0;
            dc_rsp_data  <= '0;
            if (rsp_hit) begin
                if (rsp_owner == SIDE_DC) begin
                    dc_rsp_valid <= 1'b1;
                    dc_rsp_data  <= rsp_wr ? '0 : mem_rsp_rdata;
                end else if (!rsp_drop && !ic_flush) begin
                    ic_rsp_valid <= 1'b1;
                    ic_rsp_data  <= mem_rsp_rdata;
                end
            end
            if (mem_rsp_valid && !tag_valid[mem_rsp_tag]) protocol_err <= 1'b1;
        end
    end

endmodule
